// File: rtl/apu_pkg.sv
// Shared constants and types for the APU delta-modulation channel.
// Pure declarations, no logic and no latency.
// No flow control; consumers sample these constants directly.
package apu_pkg;

    // Sample memory window: fetches start inside $C000-$FFFF and wrap into $8000
    localparam logic [15:0] DMC_ADDR_BASE = 16'hC000;
    localparam logic [15:0] DMC_ADDR_WRAP = 16'h8000;

    // Output-unit clock periods in CPU clocks, indexed by $4010[3:0]
    localparam logic [8:0] DMC_RATE_NTSC [16] = '{
        9'd428, 9'd380, 9'd340, 9'd320, 9'd286, 9'd254, 9'd226, 9'd214,
        9'd190, 9'd160, 9'd142, 9'd128, 9'd106, 9'd84,  9'd72,  9'd54
    };

    localparam logic [8:0] DMC_RATE_PAL [16] = '{
        9'd398, 9'd354, 9'd316, 9'd298, 9'd276, 9'd236, 9'd210, 9'd198,
        9'd176, 9'd148, 9'd132, 9'd118, 9'd98,  9'd78,  9'd66,  9'd50
    };

    // Sample reader: either idle or holding a fetch request towards the arbiter
    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_REQ  = 1'b1
    } rd_state_t;

    // Period lookup for the selected video standard
    function automatic logic [8:0] dmc_period(input logic pal, input logic [3:0] idx);
        return pal ? DMC_RATE_PAL[idx] : DMC_RATE_NTSC[idx];
    endfunction

endpackage

// File: rtl/apu_dmc_reader.sv
// DMC sample reader: fetches sample bytes into the one-byte buffer over the DMA bus.
// Request rises the cycle after (buffer empty && bytes remain); byte lands the cycle after grant.
// dma_req is held stable until dma_gnt; an enable-off write withdraws it and discards a same-cycle grant.
module apu_dmc_reader
    import apu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en_we,
    input  logic        en,
    input  logic [15:0] start_addr,
    input  logic [11:0] length,
    input  logic        loop_en,
    input  logic        irq_en,
    input  logic        irq_clr,
    input  logic        buf_take,
    output logic        buf_full,
    output logic [7:0]  buf_data,
    output logic        dma_req,
    output logic [15:0] dma_addr,
    input  logic        dma_gnt,
    input  logic [7:0]  dma_data,
    output logic        act,
    output logic        irq
);

    rd_state_t   state;
    rd_state_t   state_nxt;
    logic [15:0] cur_addr;
    logic [11:0] bytes_rem;
    logic        capture;
    logic        last_byte;

    wire disable_wr = en_we && !en;
    wire enable_wr  = en_we && en;

    // Reader state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: request when the buffer needs refilling, drop on grant or disable
    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE: begin
                if (!buf_full && (bytes_rem != 12'd0) && !disable_wr) begin
                    state_nxt = RD_REQ;
                end
            end
            RD_REQ: begin
                if (disable_wr || dma_gnt) begin
                    state_nxt = RD_IDLE;
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    // Outputs decoded from state; a grant only counts if not cancelled in the same cycle
    always_comb begin
        dma_req   = (state == RD_REQ);
        capture   = (state == RD_REQ) && dma_gnt && !disable_wr;
        last_byte = capture && (bytes_rem == 12'd1);
    end

    assign dma_addr = cur_addr;
    assign act      = (bytes_rem != 12'd0);

    // Address and byte counter: enable writes, post-grant advance, loop restart
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr  <= DMC_ADDR_BASE;
            bytes_rem <= 12'd0;
        end else if (disable_wr) begin
            bytes_rem <= 12'd0;
        end else if (enable_wr && (bytes_rem == 12'd0)) begin
            cur_addr  <= start_addr;
            bytes_rem <= length;
        end else if (capture) begin
            if (last_byte && loop_en) begin
                cur_addr  <= start_addr;
                bytes_rem <= length;
            end else begin
                cur_addr  <= (cur_addr == 16'hFFFF) ? DMC_ADDR_WRAP : cur_addr + 16'd1;
                bytes_rem <= bytes_rem - 12'd1;
            end
        end
    end

    // Sample buffer: filled by a grant, emptied when the output unit reloads its shifter
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_data <= 8'h00;
        end else if (capture) begin
            buf_full <= 1'b1;
            buf_data <= dma_data;
        end else if (buf_take) begin
            buf_full <= 1'b0;
        end
    end

    // Interrupt flag: set when a non-looping sample ends, clear request takes priority
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end else if (last_byte && !loop_en && irq_en) begin
            irq <= 1'b1;
        end
    end

endmodule

// File: rtl/apu_dmc.sv
// APU delta-modulation channel: registers, rate timer and 7-bit output unit around the sample reader.
// Output level moves one step per timer period; register writes take effect on the next clk.
// Bus fetches are paced by buffer drain; the arbiter may stall dma_gnt indefinitely.
module apu_dmc
    import apu_pkg::*;
#(
    parameter bit PAL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_we,
    input  logic [1:0]  reg_addr,
    input  logic [7:0]  reg_wdata,
    input  logic        en_we,
    input  logic        en,
    output logic        dma_req,
    output logic [15:0] dma_addr,
    input  logic        dma_gnt,
    input  logic [7:0]  dma_data,
    output logic [6:0]  out,
    output logic        act,
    output logic        irq
);

    logic        irq_en;
    logic        loop_en;
    logic [3:0]  rate_idx;
    logic [7:0]  start_reg;
    logic [7:0]  len_reg;
    logic [15:0] start_addr;
    logic [11:0] length;
    logic        irq_clr;

    logic [8:0]  timer;
    logic        out_clk;

    logic [7:0]  shift_reg;
    logic [2:0]  bits_rem;
    logic        silence;
    logic [6:0]  level;
    logic        buf_full;
    logic [7:0]  buf_data;
    logic        buf_take;

    // Sample start in 64-byte pages above $C000; length in 16-byte units plus one
    assign start_addr = DMC_ADDR_BASE + {2'b00, start_reg, 6'b000000};
    assign length     = {len_reg, 4'b0000} + 12'd1;
    assign irq_clr    = en_we || (reg_we && (reg_addr == 2'd0) && !reg_wdata[7]);

    // $4010 / $4012 / $4013 configuration registers ($4011 goes straight to the level)
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en    <= 1'b0;
            loop_en   <= 1'b0;
            rate_idx  <= 4'd0;
            start_reg <= 8'h00;
            len_reg   <= 8'h00;
        end else if (reg_we) begin
            case (reg_addr)
                2'd0: begin
                    irq_en   <= reg_wdata[7];
                    loop_en  <= reg_wdata[6];
                    rate_idx <= reg_wdata[3:0];
                end
                2'd2:    start_reg <= reg_wdata;
                2'd3:    len_reg   <= reg_wdata;
                default: ;
            endcase
        end
    end

    // Rate timer: counts down, reload picks up a new rate only at the wrap
    assign out_clk = (timer == 9'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= dmc_period(PAL, 4'd0) - 9'd1;
        end else if (out_clk) begin
            timer <= dmc_period(PAL, rate_idx) - 9'd1;
        end else begin
            timer <= timer - 9'd1;
        end
    end

    // The shifter swallows the buffer at the end of each 8-bit output cycle
    assign buf_take = out_clk && (bits_rem == 3'd0) && buf_full;

    // Output unit: step level by +/-2 per bit with saturation, CPU level write wins
    always_ff @(posedge clk) begin
        if (reset) begin
            level     <= 7'd0;
            shift_reg <= 8'h00;
            bits_rem  <= 3'd7;
            silence   <= 1'b1;
        end else begin
            if (out_clk) begin
                if (!silence) begin
                    if (shift_reg[0] && (level <= 7'd125)) begin
                        level <= level + 7'd2;
                    end else if (!shift_reg[0] && (level >= 7'd2)) begin
                        level <= level - 7'd2;
                    end
                end
                if (bits_rem == 3'd0) begin
                    bits_rem <= 3'd7;
                    if (buf_full) begin
                        shift_reg <= buf_data;
                        silence   <= 1'b0;
                    end else begin
                        shift_reg <= shift_reg >> 1;
                        silence   <= 1'b1;
                    end
                end else begin
                    bits_rem  <= bits_rem - 3'd1;
                    shift_reg <= shift_reg >> 1;
                end
            end
            if (reg_we && (reg_addr == 2'd1)) begin
                level <= reg_wdata[6:0];
            end
        end
    end

    assign out = level;

    apu_dmc_reader u_reader (
        .clk        (clk),
        .reset      (reset),
        .en_we      (en_we),
        .en         (en),
        .start_addr (start_addr),
        .length     (length),
        .loop_en    (loop_en),
        .irq_en     (irq_en),
        .irq_clr    (irq_clr),
        .buf_take   (buf_take),
        .buf_full   (buf_full),
        .buf_data   (buf_data),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_gnt    (dma_gnt),
        .dma_data   (dma_data),
        .act        (act),
        .irq        (irq)
    );

endmodule
